// File: rtl/mer_pkg.sv
// ---------------------------------------------------------------------------
// mer_pkg
// Shared definitions for the modulation-error-rate monitor and the 4-ASK
// slicer. It holds the 4-ASK decision levels, the slicer threshold, the
// datapath widths and the monitor FSM state type.
// The slicer is reused by the receiver team, so the level constants live
// here rather than inside either module.
// ---------------------------------------------------------------------------
package mer_pkg;

  // Symbol sample width (signed 1s17).
  localparam int DATA_W = 18;

  // The error is one bit wider than a sample, so rx - decision cannot wrap.
  localparam int ERR_W = 19;

  // The squared error is exact in 36 bits (2s34).
  localparam int SQ_W = 36;

  // Depth of the reference delay line. The flush phase also waits this many
  // symbols.
  localparam int DLY_DEPTH = 16;

  // 4-ASK decision levels in 1s17.
  localparam logic signed [DATA_W-1:0] LVL_POS_HI = 18'sd98304;
  localparam logic signed [DATA_W-1:0] LVL_POS_LO = 18'sd32768;
  localparam logic signed [DATA_W-1:0] LVL_NEG_LO = -18'sd32768;
  localparam logic signed [DATA_W-1:0] LVL_NEG_HI = -18'sd98304;

  // Decision thresholds. The inner threshold sits at zero.
  localparam logic signed [DATA_W-1:0] THRESH     = 18'sd65536;
  localparam logic signed [DATA_W-1:0] NEG_THRESH = -18'sd65536;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } state_t;

endpackage

// File: rtl/slicer_4ask.sv
// ---------------------------------------------------------------------------
// slicer_4ask
// Combinational hard-decision slicer for 4-ASK symbols in signed 1s17.
// The decision regions are:
//   rx >= 65536            -> +98304
//   0 <= rx <= 65535       -> +32768
//   -65536 <= rx <= -1     -> -32768
//   rx < -65536            -> -98304
// Ports:
//   i_rx   in  18  signed received sample
//   o_dec  out 18  signed decided level
// ---------------------------------------------------------------------------
module slicer_4ask
  import mer_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_rx,
  output logic signed [DATA_W-1:0] o_dec
);

  // Ordered compare chain.
  // The boundary values 65536 and -65536 fall in the regions listed above.
  always_comb begin
    o_dec = LVL_NEG_HI;
    if (i_rx >= THRESH) begin
      o_dec = LVL_POS_HI;
    end else if (i_rx >= 18'sd0) begin
      o_dec = LVL_POS_LO;
    end else if (i_rx >= NEG_THRESH) begin
      o_dec = LVL_NEG_LO;
    end
  end

endmodule

// File: rtl/mer_monitor.sv
// ---------------------------------------------------------------------------
// mer_monitor
// Measures mean squared error and symbol decision errors of a 4-ASK
// receiver output. The monitor compares the receiver output against a
// delayed copy of the transmitted reference. Each measurement window is
// 2^LOG2_WIN symbols long, and windows run back to back.
// Ports:
//   clk          in   1            system clock
//   reset        in   1            async active-high reset
//   sym_clk      in   1            symbol-rate enable (one clk wide)
//   clear_accum  in   1            synchronous restart of the measurement
//   delay_sel    in   4            reference delay tap select (tap = value+1)
//   ref_sym      in   18           signed 1s17 transmitted symbol
//   rx_in        in   18           signed 1s17 receiver output
//   dec_out      out  18           signed 1s17 slicer decision
//   mean_err_sq  out  36           unsigned mean squared error (2s34)
//   sym_err_cnt  out  LOG2_WIN+1   decision errors in the last window
//   meas_valid   out  1            one-clk pulse while new results present
// ---------------------------------------------------------------------------
module mer_monitor
  import mer_pkg::*;
#(
  parameter int LOG2_WIN = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sym_clk,
  input  logic                     clear_accum,
  input  logic [3:0]               delay_sel,
  input  logic signed [DATA_W-1:0] ref_sym,
  input  logic signed [DATA_W-1:0] rx_in,
  output logic signed [DATA_W-1:0] dec_out,
  output logic [SQ_W-1:0]          mean_err_sq,
  output logic [LOG2_WIN:0]        sym_err_cnt,
  output logic                     meas_valid
);

  // The accumulator is wide enough to sum a full window of worst-case
  // squared errors, so it needs no saturation logic.
  localparam int ACC_W = SQ_W + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam logic [3:0] FLUSH_LAST = 4'(DLY_DEPTH - 1);

  state_t                     r_state;
  logic signed [DATA_W-1:0]   r_rx;
  logic signed [DATA_W-1:0]   r_dly [DLY_DEPTH];
  logic signed [DATA_W-1:0]   r_dec;
  logic [3:0]                 r_flushCnt;
  logic [ACC_W-1:0]           r_acc;
  logic [CNT_W-1:0]           r_errCnt;
  logic [LOG2_WIN-1:0]        r_symCnt;
  logic [SQ_W-1:0]            r_mean;
  logic [CNT_W-1:0]           r_symErr;
  logic                       r_valid;

  logic signed [DATA_W-1:0]   w_dec;
  logic signed [DATA_W-1:0]   w_refD;
  logic signed [ERR_W-1:0]    w_err;
  logic signed [SQ_W-1:0]     w_errExt;
  logic [SQ_W-1:0]            w_errSq;
  logic                       w_symErr;
  logic [ACC_W-1:0]           w_accNext;
  logic [CNT_W-1:0]           w_errCntNext;
  logic                       w_lastSym;

  slicer_4ask u_slicer (
    .i_rx  (r_rx),
    .o_dec (w_dec)
  );

  // Both operands are sign-extended before the subtraction, so the 19-bit
  // error is exact. The 36-bit square of a 19-bit value is also exact.
  assign w_err        = ERR_W'(r_rx) - ERR_W'(w_dec);
  assign w_errExt     = SQ_W'(w_err);
  assign w_errSq      = $unsigned(w_errExt * w_errExt);

  // r_dly[k] holds the reference from k+1 symbols ago.
  assign w_refD       = r_dly[delay_sel];
  assign w_symErr     = (w_dec != w_refD);
  assign w_accNext    = r_acc + ACC_W'(w_errSq);
  assign w_errCntNext = r_errCnt + CNT_W'(w_symErr);
  assign w_lastSym    = (r_symCnt == {LOG2_WIN{1'b1}});

  // Sample pipeline: the received sample, the reference delay line and the
  // registered decision. All of them advance only on symbol enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx  <= '0;
      r_dec <= '0;
      for (int i = 0; i < DLY_DEPTH; i++) begin
        r_dly[i] <= '0;
      end
    end else if (sym_clk) begin
      r_rx     <= rx_in;
      r_dec    <= w_dec;
      r_dly[0] <= ref_sym;
      for (int i = 1; i < DLY_DEPTH; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  // Measurement FSM.
  // The window's final symbol is folded into the results on the same edge
  // that enters DUMP. That way mean_err_sq and sym_err_cnt are already
  // valid during the one clk in which meas_valid is high. DUMP can never
  // coincide with a symbol enable, because enables are at least two clks
  // apart. clear_accum takes priority over everything, including the final
  // symbol of a window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FLUSH;
      r_flushCnt <= '0;
      r_acc      <= '0;
      r_errCnt   <= '0;
      r_symCnt   <= '0;
      r_mean     <= '0;
      r_symErr   <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (clear_accum) begin
        r_state    <= FLUSH;
        r_flushCnt <= '0;
        r_acc      <= '0;
        r_errCnt   <= '0;
        r_symCnt   <= '0;
      end else begin
        case (r_state)
          FLUSH: begin
            if (sym_clk) begin
              if (r_flushCnt == FLUSH_LAST) begin
                r_state    <= ACCUM;
                r_flushCnt <= '0;
                r_acc      <= '0;
                r_errCnt   <= '0;
                r_symCnt   <= '0;
              end else begin
                r_flushCnt <= r_flushCnt + 4'd1;
              end
            end
          end
          ACCUM: begin
            if (sym_clk) begin
              if (w_lastSym) begin
                r_mean   <= w_accNext[ACC_W-1:LOG2_WIN];
                r_symErr <= w_errCntNext;
                r_valid  <= 1'b1;
                r_state  <= DUMP;
                r_acc    <= '0;
                r_errCnt <= '0;
                r_symCnt <= '0;
              end else begin
                r_acc    <= w_accNext;
                r_errCnt <= w_errCntNext;
                r_symCnt <= r_symCnt + 1'b1;
              end
            end
          end
          DUMP: begin
            r_state  <= ACCUM;
            r_acc    <= '0;
            r_errCnt <= '0;
            r_symCnt <= '0;
          end
          default: begin
            r_state <= FLUSH;
          end
        endcase
      end
    end
  end

  assign dec_out     = r_dec;
  assign mean_err_sq = r_mean;
  assign sym_err_cnt = r_symErr;
  assign meas_valid  = r_valid;

endmodule

// File: tb/tb_mer_monitor.sv
// ---------------------------------------------------------------------------
// tb_mer_monitor
// Directed, table-driven bench for mer_monitor with LOG2_WIN=4
// (16-symbol windows). A symbol enable is issued every 4 clks.
// Each table entry restarts the measurement and runs 16 flush symbols
// plus 16 window symbols. It then checks the measurement pulse, the mean
// squared error, the decision error count and the slicer output.
// Hand-written sequences cover clear in mid-window, clear on the final
// symbol, and reset in mid-window.
// ---------------------------------------------------------------------------
module tb_mer_monitor;

  localparam int LW = 4;

  logic               clk;
  logic               reset;
  logic               sym_clk;
  logic               clear_accum;
  logic [3:0]         delay_sel;
  logic signed [17:0] ref_sym;
  logic signed [17:0] rx_in;
  logic signed [17:0] dec_out;
  logic [35:0]        mean_err_sq;
  logic [LW:0]        sym_err_cnt;
  logic               meas_valid;

  int checks = 0;
  int fails  = 0;
  int validCount = 0;
  int symIdx = 0;

  // rxMode 0: rx = ref + param. rxMode 1: rx = param (constant).
  // refMode 0: repeating +98304,-32768,+32768,-98304.
  // refMode 1: alternating +98304/-98304.
  typedef struct {
    int          rxMode;
    int          refMode;
    int          param;
    logic [3:0]  dly;
    longint      expMean;
    int          expErrs;
    int          expDec;
    bit          checkDec;
  } vec_t;

  vec_t vecs [10];

  mer_monitor #(.LOG2_WIN(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .sym_clk     (sym_clk),
    .clear_accum (clear_accum),
    .delay_sel   (delay_sel),
    .ref_sym     (ref_sym),
    .rx_in       (rx_in),
    .dec_out     (dec_out),
    .mean_err_sq (mean_err_sq),
    .sym_err_cnt (sym_err_cnt),
    .meas_valid  (meas_valid)
  );

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count measurement pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (meas_valid) validCount++;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issue one symbol: drive the data, pulse sym_clk for one clk, then idle
  // for 3 clks.
  task automatic applyStimulus(input logic signed [17:0] rx, input logic signed [17:0] rf, input bit clr);
    @(posedge clk); #1;
    rx_in = rx; ref_sym = rf; sym_clk = 1'b1; clear_accum = clr;
    @(posedge clk); #1;
    sym_clk = 1'b0; clear_accum = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  function automatic int seqVal(input int i);
    case (i % 4)
      0:       return 98304;
      1:       return -32768;
      2:       return 32768;
      default: return -98304;
    endcase
  endfunction

  task automatic runSymbols(input int n, input int rxMode, input int refMode, input int param);
    int rf;
    int rx;
    for (int k = 0; k < n; k++) begin
      rf = (refMode == 0) ? seqVal(symIdx) : ((symIdx % 2 == 0) ? 98304 : -98304);
      rx = (rxMode == 0) ? rf + param : param;
      applyStimulus(18'(rx), 18'(rf), 1'b0);
      symIdx++;
    end
  endtask

  task automatic clearAccum();
    @(posedge clk); #1 clear_accum = 1'b1;
    @(posedge clk); #1 clear_accum = 1'b0;
  endtask

  initial begin
    int v0;

    vecs[0] = '{0, 0,      0, 4'd0,          0,  0,      0, 1'b0};
    vecs[1] = '{0, 0,   4096, 4'd0,   16777216,  0,      0, 1'b0};
    vecs[2] = '{0, 0,  -4096, 4'd0,   16777216,  0,      0, 1'b0};
    vecs[3] = '{0, 1,      0, 4'd1,          0, 16,      0, 1'b0};
    vecs[4] = '{1, 1,  65536, 4'd0, 1073741824,  8,  98304, 1'b1};
    vecs[5] = '{1, 1, -65536, 4'd0, 1073741824, 16, -32768, 1'b1};
    vecs[6] = '{1, 1,  65535, 4'd0, 1073676289, 16,  32768, 1'b1};
    vecs[7] = '{1, 1, -65537, 4'd0, 1073676289,  8, -98304, 1'b1};
    vecs[8] = '{1, 1,      0, 4'd0, 1073741824, 16,  32768, 1'b1};
    vecs[9] = '{1, 1,     -1, 4'd0, 1073676289, 16, -32768, 1'b1};

    reset = 1'b1; sym_clk = 1'b0; clear_accum = 1'b0;
    delay_sel = 4'd0; ref_sym = '0; rx_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset dec_out", $signed(dec_out), 0);
    checkOutput("reset mean_err_sq", mean_err_sq, 0);
    checkOutput("reset sym_err_cnt", sym_err_cnt, 0);
    checkOutput("reset meas_valid", meas_valid, 0);

    // Table-driven windows.
    for (int v = 0; v < 10; v++) begin
      delay_sel = vecs[v].dly;
      clearAccum();
      v0 = validCount;
      runSymbols(31, vecs[v].rxMode, vecs[v].refMode, vecs[v].param);
      checkOutput($sformatf("vec%0d early valid", v), validCount - v0, 0);
      runSymbols(1, vecs[v].rxMode, vecs[v].refMode, vecs[v].param);
      checkOutput($sformatf("vec%0d valid pulses", v), validCount - v0, 1);
      checkOutput($sformatf("vec%0d mean_err_sq", v), mean_err_sq, vecs[v].expMean);
      checkOutput($sformatf("vec%0d sym_err_cnt", v), sym_err_cnt, vecs[v].expErrs);
      if (vecs[v].checkDec)
        checkOutput($sformatf("vec%0d dec_out", v), $signed(dec_out), vecs[v].expDec);
    end

    // Clear at symbol 8 of a window: results hold, and the next pulse
    // comes a full flush plus window later.
    delay_sel = 4'd0;
    clearAccum();
    runSymbols(24, 0, 0, 4096);
    clearAccum();
    v0 = validCount;
    runSymbols(31, 0, 0, 4096);
    checkOutput("midclear no valid", validCount - v0, 0);
    checkOutput("midclear mean hold", mean_err_sq, 1073676289);
    checkOutput("midclear cnt hold", sym_err_cnt, 16);
    runSymbols(1, 0, 0, 4096);
    checkOutput("midclear valid", validCount - v0, 1);
    checkOutput("midclear mean", mean_err_sq, 16777216);
    checkOutput("midclear cnt", sym_err_cnt, 0);

    // Clear coinciding with the final window symbol: the clear wins.
    delay_sel = 4'd1;
    clearAccum();
    v0 = validCount;
    runSymbols(31, 0, 1, 0);
    applyStimulus((symIdx % 2 == 0) ? 18'sd98304 : -18'sd98304,
                  (symIdx % 2 == 0) ? 18'sd98304 : -18'sd98304, 1'b1);
    symIdx++;
    checkOutput("lastclear no valid", validCount - v0, 0);
    checkOutput("lastclear mean hold", mean_err_sq, 16777216);
    runSymbols(31, 0, 1, 0);
    checkOutput("lastclear still no valid", validCount - v0, 0);
    runSymbols(1, 0, 1, 0);
    checkOutput("lastclear valid", validCount - v0, 1);
    checkOutput("lastclear mean", mean_err_sq, 0);
    checkOutput("lastclear cnt", sym_err_cnt, 16);

    // Reset in mid-window: outputs clear at once, and the window restarts.
    delay_sel = 4'd0;
    clearAccum();
    runSymbols(24, 0, 0, 4096);
    @(posedge clk); #1 reset = 1'b1;
    #2;
    checkOutput("midreset dec_out", $signed(dec_out), 0);
    checkOutput("midreset mean_err_sq", mean_err_sq, 0);
    checkOutput("midreset sym_err_cnt", sym_err_cnt, 0);
    checkOutput("midreset meas_valid", meas_valid, 0);
    #3 reset = 1'b0;
    v0 = validCount;
    runSymbols(31, 0, 0, 4096);
    checkOutput("midreset no valid", validCount - v0, 0);
    runSymbols(1, 0, 0, 4096);
    checkOutput("midreset valid", validCount - v0, 1);
    checkOutput("midreset mean", mean_err_sq, 16777216);
    checkOutput("midreset cnt", sym_err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mer_monitor.md
MER_MONITOR -- requirements
Module: mer_monitor

Interface
REQ-001 Parameter: LOG2_WIN, default 14, log2 of symbols per measurement window (legal 4..20).
REQ-002 Ports (clock and reset first); one clock; reset is asynchronous and active-high:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- sym_clk  in  1  symbol-rate enable, one clk wide, pulses ≥2 clk apart
- clear_accum  in  1  sync restart of measurement
- delay_sel  in  4  reference alignment, taps 1..16 (value+1)
- ref_sym  in  18  signed 1s17 transmitted 4-ASK symbol
- rx_in  in  18  signed 1s17 decimated receiver output
- dec_out  out  18  signed 1s17 slicer decision
- mean_err_sq  out  36  unsigned mean squared error, 2s34
- sym_err_cnt  out  LOG2_WIN+1  decision errors in last window
- meas_valid  out  1  one-clk pulse when outputs update

Function
REQ-003 All sampling gated by sym_clk; no state changes on clk cycles without sym_clk except DUMP and clear_accum.
REQ-004 rx_in is registered on sym_clk into rx_reg; ref_sym is shifted into a 16-deep delay line on sym_clk; ref_d = tap delay_sel+1.
REQ-005 Slicer on rx_reg: ≥65536 -> +98304; 0..65535 -> +32768; -65536..-1 -> -32768; < -65536 -> -98304.
REQ-006 dec_out = slicer(rx_reg), registered on sym_clk (one symbol latency after rx_reg).
REQ-007 err = rx_reg - slicer(rx_reg), 19-bit signed; err_sq = err*err, 36-bit unsigned, exact, no truncation.
REQ-008 Accumulator width 36+LOG2_WIN; cannot overflow within a window; no saturation logic.
REQ-009 Symbol error: slicer(rx_reg) != ref_d increments err counter.
REQ-010 FSM states FLUSH, ACCUM, DUMP.
REQ-011 FLUSH: count 16 sym_clk pulses (fill delay line), then -> ACCUM with accumulator, err counter, sym counter at 0.
REQ-012 ACCUM: each sym_clk adds err_sq, updates err counter, increments sym counter; on the pulse where sym counter = 2^LOG2_WIN-1 -> DUMP.
REQ-013 DUMP (one clk): mean_err_sq <= acc[35+LOG2_WIN:LOG2_WIN], sym_err_cnt <= err counter, meas_valid = 1, accumulators and sym counter cleared; -> ACCUM.
REQ-014 meas_valid is high only in DUMP; windows are back-to-back, no symbol dropped.
REQ-015 clear_accum high in any state: -> FLUSH next clk, accumulators and counters cleared, mean_err_sq/sym_err_cnt hold last values, no meas_valid.
REQ-016 clear_accum coinciding with final window symbol: clear wins, no DUMP.
REQ-017 delay_sel changes take effect on next sym_clk; results for the current window are undefined until clear_accum is applied.

Reset
REQ-018 reset: all outputs, rx_reg, delay line, accumulators, counters to 0; state FLUSH.
REQ-019 reset asserted mid-ACCUM or DUMP aborts the window, no meas_valid pulse.

Structure
REQ-020 Shared package mer_pkg: level constants (±32768, ±98304), threshold 65536, state enum, ERR_W=19, SQ_W=36.
REQ-021 One sub-module: slicer_4ask (combinational, 18-bit in, 18-bit decision out), reused by the receiver team.
REQ-022 Target size: 120-400 RTL lines; single clock domain, no latches.

Verification (bench LOG2_WIN=4; sym_clk every 4 clk)
REQ-023 ref_sym = rx_in = sequence +98304,-32768,+32768,-98304, delay_sel matched -> after 16 flush+16 symbols meas_valid pulse, mean_err_sq=0, sym_err_cnt=0.
REQ-024 rx_in = ref_sym+4096, aligned -> mean_err_sq=16777216, sym_err_cnt=0.
REQ-025 alternating ±98304, delay_sel one tap off -> sym_err_cnt=16, mean_err_sq=0.
REQ-026 rx_in constant 65536 -> dec_out=+98304, mean_err_sq=1073741824; rx_in constant -65536 -> dec_out=-32768, same mean.
REQ-027 clear_accum at symbol 8 of a window -> no meas_valid for next 32 symbols, outputs hold prior values, then normal pulse.
REQ-028 reset pulse mid-ACCUM -> all outputs 0 immediately, next meas_valid only after 32 further symbols.
